alu_result_reg: RTL

//  Downstream stage of the 4-bit ALU: captures the 8-bit ALU result into a register
//  on a debounced pushbutton press. It returns the low nibble to the ALU B operand,

---
 rtl/alu_result_reg.sv | 78 +++++++
 1 files changed

// File: rtl/alu_result_reg.sv
// alu_result_reg: debounced pushbutton capture of the ALU result with B-operand feedback and capture count
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   alu_out    combinational ALU result, sampled only when a press is accepted
//   capture_n  raw active-low pushbutton, asynchronous to clk
//   clear      synchronous clear of result and op_count
//   result     registered ALU result
//   b_feedback result[3:0], fed back as the ALU B operand
//   captured   one-cycle pulse in the cycle result takes a new value
//   op_count   captures since reset/clear, wraps 255->0
//   busy       high whenever the debouncer is not idle
module alu_result_reg #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_out,
  input  logic       capture_n,
  input  logic       clear,
  output logic [7:0] result,
  output logic [3:0] b_feedback,
  output logic       captured,
  output logic [7:0] op_count,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, CAPTURE, HELD, REL_WAIT} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic sync1, sync2, btn, take;
  assign btn = ~sync2;
  assign take = state_n == CAPTURE;
  assign captured = state == CAPTURE;
  assign busy = state != IDLE;
  assign b_feedback = result[3:0];
  // Reset lands in REL_WAIT so a button held through reset must be released before it can capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= REL_WAIT;
      cnt <= '0;
      result <= '0;
      op_count <= '0;
    end else begin
      sync1 <= capture_n;
      sync2 <= sync1;
      state <= state_n;
      cnt <= cnt_n;
      if (clear) begin
        result <= '0;
        op_count <= '0;
      end else if (take) begin
        result <= alu_out;
        op_count <= op_count + 8'd1;
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE:       if (btn) begin state_n = PRESS_WAIT; cnt_n = ONE; end
      PRESS_WAIT: if (!btn) begin state_n = IDLE; cnt_n = '0; end
                  else if (cnt == LIMIT) begin state_n = CAPTURE; cnt_n = '0; end
                  else cnt_n = cnt + ONE;
      CAPTURE:    state_n = HELD;
      HELD:       if (!btn) begin state_n = REL_WAIT; cnt_n = ONE; end
      REL_WAIT:   if (btn) begin state_n = HELD; cnt_n = '0; end
                  else if (cnt == LIMIT) begin state_n = IDLE; cnt_n = '0; end
                  else cnt_n = cnt + ONE;
      default:    begin state_n = REL_WAIT; cnt_n = '0; end
    endcase
  end
endmodule
